// File: rtl/cpu_bus_master.sv
// cpu_bus_master: 68040-protocol bus initiator for FPGA-internal engines.
// Takes a single-transfer request, arbitrates with BR/BG/BB, issues the
// address phase with TS/TIP, then collects TA/TEA-terminated beats.
//
// Ports:
//   i_clk, i_rst              clock, synchronous active-low reset
//   i_req_*                   request strobe/address/direction/size
//   i_wr_data                 write data for o_beat_idx (combinational path)
//   o_busy, o_beat_ack,       request-side status, per-beat handshake and
//   o_beat_idx, o_rd_data,    captured read data, completion with error and
//   o_done, o_err, o_timeout  timeout flags
//   o_br, i_bg, i_bb_in,      arbitration (active low)
//   o_bb_out, o_bb_oe
//   o_a_out, o_a_oe, i_d_in,  address/data buses and enables
//   o_d_out, o_d_oe
//   o_ts, o_tip, o_rw, o_siz, transfer control/attributes
//   o_tt, o_tm, i_ta, i_tea
module cpu_bus_master #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_stb,
    input  logic [31:0] i_req_addr,
    input  logic        i_req_rw,
    input  logic [1:0]  i_req_siz,
    input  logic [31:0] i_wr_data,
    output logic        o_busy,
    output logic        o_beat_ack,
    output logic [1:0]  o_beat_idx,
    output logic [31:0] o_rd_data,
    output logic        o_done,
    output logic        o_err,
    output logic        o_timeout,
    output logic        o_br,
    input  logic        i_bg,
    input  logic        i_bb_in,
    output logic        o_bb_out,
    output logic        o_bb_oe,
    output logic [31:0] o_a_out,
    output logic        o_a_oe,
    input  logic [31:0] i_d_in,
    output logic [31:0] o_d_out,
    output logic        o_d_oe,
    output logic        o_ts,
    output logic        o_tip,
    output logic        o_rw,
    output logic [1:0]  o_siz,
    output logic [1:0]  o_tt,
    output logic [2:0]  o_tm,
    input  logic        i_ta,
    input  logic        i_tea
);

    typedef enum logic [2:0] {StIdle, StArb, StAddr, StData, StRelease} state_t;

    localparam logic [1:0] SizLine     = 2'b11;
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

    state_t      r_state, w_state;
    logic        r_busy, w_busy;
    logic        r_beat_ack, w_beat_ack;
    logic [1:0]  r_beat_idx, w_beat_idx;
    logic [31:0] r_rd_data, w_rd_data;
    logic        r_done, w_done;
    logic        r_err, w_err;
    logic        r_timeout, w_timeout;
    logic        r_br, w_br;
    logic        r_bb_out, w_bb_out;
    logic        r_bb_oe, w_bb_oe;
    logic [31:0] r_a_out, w_a_out;
    logic        r_a_oe, w_a_oe;
    logic        r_d_oe, w_d_oe;
    logic        r_ts, w_ts;
    logic        r_tip, w_tip;
    logic        r_rw, w_rw;
    logic [1:0]  r_siz, w_siz;
    logic [1:0]  r_beats_left, w_beats_left;
    logic [7:0]  r_wait_cnt, w_wait_cnt;
    logic        w_go_release;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state      <= StIdle;
            r_busy       <= 1'b0;
            r_beat_ack   <= 1'b0;
            r_beat_idx   <= 2'd0;
            r_rd_data    <= 32'd0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_timeout    <= 1'b0;
            r_br         <= 1'b1;
            r_bb_out     <= 1'b1;
            r_bb_oe      <= 1'b0;
            r_a_out      <= 32'd0;
            r_a_oe       <= 1'b0;
            r_d_oe       <= 1'b1;
            r_ts         <= 1'b1;
            r_tip        <= 1'b1;
            r_rw         <= 1'b1;
            r_siz        <= 2'b00;
            r_beats_left <= 2'd0;
            r_wait_cnt   <= 8'd0;
        end else begin
            r_state      <= w_state;
            r_busy       <= w_busy;
            r_beat_ack   <= w_beat_ack;
            r_beat_idx   <= w_beat_idx;
            r_rd_data    <= w_rd_data;
            r_done       <= w_done;
            r_err        <= w_err;
            r_timeout    <= w_timeout;
            r_br         <= w_br;
            r_bb_out     <= w_bb_out;
            r_bb_oe      <= w_bb_oe;
            r_a_out      <= w_a_out;
            r_a_oe       <= w_a_oe;
            r_d_oe       <= w_d_oe;
            r_ts         <= w_ts;
            r_tip        <= w_tip;
            r_rw         <= w_rw;
            r_siz        <= w_siz;
            r_beats_left <= w_beats_left;
            r_wait_cnt   <= w_wait_cnt;
        end
    end

    // Next-state and next-output values; outputs are registered so each
    // value below becomes visible in the cycle after the deciding edge.
    always_comb begin
        w_state      = r_state;
        w_busy       = r_busy;
        w_beat_ack   = 1'b0;
        w_beat_idx   = r_beat_idx;
        w_rd_data    = r_rd_data;
        w_done       = 1'b0;
        w_err        = r_err;
        w_timeout    = r_timeout;
        w_br         = r_br;
        w_bb_out     = r_bb_out;
        w_bb_oe      = r_bb_oe;
        w_a_out      = r_a_out;
        w_a_oe       = r_a_oe;
        w_d_oe       = r_d_oe;
        w_ts         = r_ts;
        w_tip        = r_tip;
        w_rw         = r_rw;
        w_siz        = r_siz;
        w_beats_left = r_beats_left;
        w_wait_cnt   = r_wait_cnt;
        w_go_release = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (i_req_stb) begin
                    w_state   = StArb;
                    w_busy    = 1'b1;
                    w_br      = 1'b0;
                    w_err     = 1'b0;
                    w_timeout = 1'b0;
                    w_a_out   = i_req_addr;
                    w_rw      = i_req_rw;
                    w_siz     = i_req_siz;
                    if (i_req_siz == SizLine) begin
                        w_beats_left = 2'd3;
                        w_beat_idx   = i_req_addr[3:2];
                    end else begin
                        w_beats_left = 2'd0;
                        w_beat_idx   = 2'd0;
                    end
                end
            end
            StArb: begin
                // Own the bus only when granted and no other master holds BB.
                if (!i_bg && i_bb_in) begin
                    w_state  = StAddr;
                    w_ts     = 1'b0;
                    w_tip    = 1'b0;
                    w_bb_oe  = 1'b1;
                    w_bb_out = 1'b0;
                    w_a_oe   = 1'b1;
                    w_br     = 1'b1;
                    w_d_oe   = r_rw;
                end
            end
            StAddr: begin
                w_state    = StData;
                w_ts       = 1'b1;
                w_wait_cnt = 8'd0;
            end
            StData: begin
                if (!i_tea) begin
                    // TEA wins over a simultaneous TA; no beat is reported.
                    w_err        = 1'b1;
                    w_go_release = 1'b1;
                end else if (!i_ta) begin
                    w_beat_ack = 1'b1;
                    if (r_rw) begin
                        w_rd_data = i_d_in;
                    end
                    if (r_beats_left == 2'd0) begin
                        w_go_release = 1'b1;
                    end else begin
                        w_beats_left = r_beats_left - 2'd1;
                        w_beat_idx   = r_beat_idx + 2'd1;
                        w_wait_cnt   = 8'd0;
                    end
                end else if (r_wait_cnt == TimeoutLast) begin
                    w_err        = 1'b1;
                    w_timeout    = 1'b1;
                    w_go_release = 1'b1;
                end else begin
                    w_wait_cnt = r_wait_cnt + 8'd1;
                end
            end
            StRelease: begin
                w_state = StIdle;
                w_bb_oe = 1'b0;
                w_a_oe  = 1'b0;
                w_busy  = 1'b0;
            end
            default: begin
                w_state = StIdle;
            end
        endcase

        if (w_go_release) begin
            w_state  = StRelease;
            w_tip    = 1'b1;
            w_bb_out = 1'b1;
            w_bb_oe  = 1'b1;
            w_a_oe   = 1'b1;
            w_d_oe   = 1'b1;
            w_done   = 1'b1;
        end
    end

    assign o_busy     = r_busy;
    assign o_beat_ack = r_beat_ack;
    assign o_beat_idx = r_beat_idx;
    assign o_rd_data  = r_rd_data;
    assign o_done     = r_done;
    assign o_err      = r_err;
    assign o_timeout  = r_timeout;
    assign o_br       = r_br;
    assign o_bb_out   = r_bb_out;
    assign o_bb_oe    = r_bb_oe;
    assign o_a_out    = r_a_out;
    assign o_a_oe     = r_a_oe;
    assign o_d_oe     = r_d_oe;
    assign o_ts       = r_ts;
    assign o_tip      = r_tip;
    assign o_rw       = r_rw;
    assign o_siz      = r_siz;
    // Write data follows o_beat_idx combinationally through the requester.
    assign o_d_out    = i_wr_data;
    assign o_tt       = 2'b00;
    assign o_tm       = 3'b001;

endmodule

// File: tb/tb_cpu_bus_master.sv
module tb_cpu_bus_master;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_stb;
    logic [31:0] req_addr;
    logic        req_rw;
    logic [1:0]  req_siz;
    logic [31:0] wr_data;
    logic        busy, beat_ack, done, err, timeout;
    logic [1:0]  beat_idx;
    logic [31:0] rd_data;
    logic        br, bg, bb_in, bb_out, bb_oe;
    logic [31:0] a_out;
    logic        a_oe;
    logic [31:0] d_in, d_out;
    logic        d_oe, ts, tip, rw;
    logic [1:0]  siz, tt;
    logic [2:0]  tm;
    logic        ta, tea;

    logic [31:0] wr_mem [4];
    int checks = 0;
    int errors = 0;

    // Requester supplies write data for whichever beat is on the bus.
    assign wr_data = wr_mem[beat_idx];

    always #5 clk = ~clk;

    cpu_bus_master #(.TIMEOUT_CYCLES(TO)) dut (
        .i_clk(clk), .i_rst(rst), .i_req_stb(req_stb), .i_req_addr(req_addr),
        .i_req_rw(req_rw), .i_req_siz(req_siz), .i_wr_data(wr_data),
        .o_busy(busy), .o_beat_ack(beat_ack), .o_beat_idx(beat_idx), .o_rd_data(rd_data),
        .o_done(done), .o_err(err), .o_timeout(timeout), .o_br(br), .i_bg(bg),
        .i_bb_in(bb_in), .o_bb_out(bb_out), .o_bb_oe(bb_oe), .o_a_out(a_out),
        .o_a_oe(a_oe), .i_d_in(d_in), .o_d_out(d_out), .o_d_oe(d_oe), .o_ts(ts),
        .o_tip(tip), .o_rw(rw), .o_siz(siz), .o_tt(tt), .o_tm(tm), .i_ta(ta), .i_tea(tea)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One complete transfer with the bench acting as arbiter and slave.
    // waits: idle DATA cycles before each beat's TA; tea_beat/to_beat: beat
    // that ends in TEA / never terminates (-1 none). dmode: 0 random read
    // data, 1 fixed 0xDEADBEEF, 2 beat number.
    task automatic xfer(input logic [31:0] addr, input logic rd, input logic [1:0] sz,
                        input int gdly, input int bdly,
                        input int w0, input int w1, input int w2, input int w3,
                        input int tea_beat, input int to_beat, input bit poke,
                        input bit rst_mid, input int dmode);
        int waits [4];
        int nbeats, k, cyc, budget;
        logic [1:0] idx0, eidx;
        logic [31:0] dv;
        bit fin, exp_ack, exp_done, exp_err, exp_to;
        waits = '{w0, w1, w2, w3};
        nbeats = (sz == 2'b11) ? 4 : 1;
        idx0 = (sz == 2'b11) ? addr[3:2] : 2'd0;
        for (int i = 0; i < 4; i++) wr_mem[i] = $urandom;
        exp_err = 1'b0;
        exp_to = 1'b0;

        req_addr = addr; req_rw = rd; req_siz = sz; req_stb = 1'b1;
        @(negedge clk);
        req_stb = 1'b0; req_addr = $urandom; req_rw = ~rd; req_siz = ~sz;
        chk("busy_acc", busy, 1); chk("br_acc", br, 0); chk("err_clr", err, 0);
        chk("idx_init", beat_idx, idx0);

        for (int i = 0; i < gdly + bdly; i++) begin
            bg = (i < gdly) ? 1'b1 : 1'b0;
            bb_in = (i < gdly) ? 1'b1 : 1'b0;
            @(negedge clk);
            chk("br_wait", br, 0); chk("ts_wait", ts, 1);
        end
        bg = 1'b0; bb_in = 1'b1;
        @(negedge clk);
        bg = 1'b1;
        chk("ts_addr", ts, 0); chk("tip_addr", tip, 0); chk("br_addr", br, 1);
        chk("a_oe_addr", a_oe, 1); chk("a_out_addr", a_out, addr);
        chk("bb_oe_addr", bb_oe, 1); chk("bb_out_addr", bb_out, 0);
        chk("rw_addr", rw, rd); chk("siz_addr", siz, sz);
        chk("tt", tt, 0); chk("tm", tm, 1); chk("d_oe_addr", d_oe, rd);
        @(negedge clk);

        k = 0; cyc = 0; fin = 1'b0; budget = 0;
        while (!fin && budget < 100) begin
            budget++;
            eidx = idx0 + 2'(k);
            chk("ts_data", ts, 1); chk("tip_data", tip, 0);
            chk("idx_data", beat_idx, eidx); chk("a_out_data", a_out, addr);
            chk("d_oe_data", d_oe, rd);
            if (rst_mid) begin
                rst = 1'b0;
                @(negedge clk);
                rst = 1'b1;
                chk("rst_tip", tip, 1); chk("rst_bb_oe", bb_oe, 0); chk("rst_a_oe", a_oe, 0);
                chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_br", br, 1);
                chk("rst_ts", ts, 1); chk("rst_d_oe", d_oe, 1);
                return;
            end
            ta = 1'b1; tea = 1'b1; req_stb = poke;
            d_in = (dmode == 1) ? 32'hDEAD_BEEF : (dmode == 2) ? 32'(k) : $urandom;
            if (!rd) chk("d_out", d_out, wr_mem[eidx]);
            exp_ack = 1'b0; exp_done = 1'b0;
            if (k == tea_beat && cyc == waits[k]) begin
                tea = 1'b0; ta = 1'b0; exp_done = 1'b1; exp_err = 1'b1;
            end else if (k == to_beat) begin
                if (cyc == TO - 1) begin
                    exp_done = 1'b1; exp_err = 1'b1; exp_to = 1'b1;
                end
            end else if (cyc == waits[k]) begin
                ta = 1'b0; exp_ack = 1'b1; exp_done = (k == nbeats - 1);
            end
            dv = d_in;
            @(negedge clk);
            ta = 1'b1; tea = 1'b1; req_stb = 1'b0;
            chk("beat_ack", beat_ack, exp_ack); chk("done", done, exp_done);
            if (exp_ack && rd) chk("rd_data", rd_data, dv);
            if (exp_done) begin
                chk("err", err, exp_err); chk("timeout", timeout, exp_to);
                fin = 1'b1;
            end else if (exp_ack) begin
                k++; cyc = 0;
            end else begin
                cyc++;
            end
        end
        chk("done_seen", fin, 1);

        chk("rel_tip", tip, 1); chk("rel_bb_out", bb_out, 1); chk("rel_bb_oe", bb_oe, 1);
        chk("rel_a_oe", a_oe, 1); chk("rel_d_oe", d_oe, 1); chk("rel_busy", busy, 1);
        chk("rel_ts", ts, 1);
        @(negedge clk);
        chk("idle_busy", busy, 0); chk("idle_bb_oe", bb_oe, 0); chk("idle_a_oe", a_oe, 0);
        chk("idle_done", done, 0); chk("idle_ack", beat_ack, 0);
        chk("err_hold", err, exp_err); chk("to_hold", timeout, exp_to);
        chk("idle_br", br, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb, tb_, tob;
        logic [1:0] sz;
        rst = 1'b0; req_stb = 1'b0; req_addr = '0; req_rw = 1'b1; req_siz = 2'b00;
        bg = 1'b1; bb_in = 1'b1; d_in = '0; ta = 1'b1; tea = 1'b1;
        for (int i = 0; i < 4; i++) wr_mem[i] = '0;
        repeat (3) @(negedge clk);
        chk("r_br", br, 1); chk("r_ts", ts, 1); chk("r_tip", tip, 1);
        chk("r_bb_out", bb_out, 1); chk("r_bb_oe", bb_oe, 0); chk("r_a_oe", a_oe, 0);
        chk("r_d_oe", d_oe, 1); chk("r_rw", rw, 1); chk("r_siz", siz, 0);
        chk("r_busy", busy, 0); chk("r_ack", beat_ack, 0); chk("r_done", done, 0);
        chk("r_err", err, 0); chk("r_to", timeout, 0); chk("r_idx", beat_idx, 0);
        chk("r_rd", rd_data, 0);
        rst = 1'b1;
        @(negedge clk);

        // Long read, TA on 2nd DATA cycle.
        xfer(32'h3000_0010, 1'b1, 2'b00, 0, 0, 1, 0, 0, 0, -1, -1, 1'b0, 1'b0, 1);
        // Line read at 0x8, zero-wait: beats 2,3,0,1.
        xfer(32'h0000_0008, 1'b1, 2'b11, 0, 0, 0, 0, 0, 0, -1, -1, 1'b0, 1'b0, 2);
        // Byte write with grant delayed 10 cycles, then bus busy for 2.
        xfer(32'h1234_5677, 1'b0, 2'b01, 10, 2, 0, 0, 0, 0, -1, -1, 1'b0, 1'b0, 0);
        // Line write with wait states.
        xfer(32'h0000_0004, 1'b0, 2'b11, 1, 0, 2, 0, 3, 1, -1, -1, 1'b0, 1'b0, 0);
        // TEA together with TA on beat 2 of a line read.
        xfer(32'h0000_0000, 1'b1, 2'b11, 0, 0, 0, 0, 1, 0, 2, -1, 1'b0, 1'b0, 0);
        // Timeout on a single-beat read, and on beat 1 of a burst.
        xfer(32'h4000_0000, 1'b1, 2'b00, 0, 0, 0, 0, 0, 0, -1, 0, 1'b0, 1'b0, 0);
        xfer(32'h4000_000C, 1'b1, 2'b11, 0, 0, 0, 0, 0, 0, -1, 1, 1'b0, 1'b0, 0);
        // Requests while busy are ignored.
        xfer(32'h5000_0000, 1'b0, 2'b10, 0, 1, 2, 0, 0, 0, -1, -1, 1'b1, 1'b0, 0);
        // Reset during DATA, then a normal transfer.
        xfer(32'h6000_0000, 1'b1, 2'b00, 0, 0, 3, 0, 0, 0, -1, -1, 1'b0, 1'b1, 0);
        xfer(32'h6000_0004, 1'b1, 2'b10, 0, 0, 0, 0, 0, 0, -1, -1, 1'b0, 1'b0, 0);

        for (int n = 0; n < 30; n++) begin
            sz = 2'($urandom_range(0, 3));
            nb = (sz == 2'b11) ? 4 : 1;
            tb_ = -1; tob = -1;
            if ($urandom_range(0, 7) == 0) tb_ = $urandom_range(0, nb - 1);
            else if ($urandom_range(0, 7) == 0) tob = $urandom_range(0, nb - 1);
            xfer($urandom, 1'($urandom_range(0, 1)), sz, $urandom_range(0, 3),
                 $urandom_range(0, 2), $urandom_range(0, 4), $urandom_range(0, 4),
                 $urandom_range(0, 4), $urandom_range(0, 4), tb_, tob,
                 1'($urandom_range(0, 1)), 1'b0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_bus_master.md
# cpu_bus_master

Synchronous 68040-protocol bus initiator for FPGA-internal engines (DMA, self-test, boot copy). It takes a one-transfer request from local logic, arbitrates for the processor bus with BR/BG/BB, and issues the address phase with TS/TIP. It then collects TA/TEA-terminated beats and reports per-beat data and a final status. It is the initiator counterpart of the board address decoder / TA generator and drives the same TS, TIP, TA, TEA, SIZ, TT and TM signal set.

## Interface
- TIMEOUT_CYCLES, 64: max cycles per beat without TA/TEA before abort; range 2..255.
- clk  in  1  bus clock; all bus inputs are synchronous to it.
- rst  in  1  synchronous, active-low reset.
- req_stb  in  1  request strobe; accepted only when busy=0.
- req_addr  in  32  transfer address.
- req_rw  in  1  1=read, 0=write.
- req_siz  in  2  00 long, 01 byte, 10 word, 11 line (4-beat burst).
- wr_data  in  32  write data for beat beat_idx; combinational use, must track beat_idx in the same cycle.
- busy  out  1  high from acceptance through the done cycle.
- beat_ack  out  1  one-cycle pulse per completed beat.
- beat_idx  out  2  longword index of the beat currently on the bus.
- rd_data  out  32  captured read data; valid while beat_ack=1.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done: transfer ended by TEA or timeout.
- timeout  out  1  valid with done: err caused by timeout.
- br  out  1  bus request, active low.
- bg  in  1  bus grant, active low.
- bb_in  in  1  bus busy, sampled, active low.
- bb_out  out  1  bus busy drive value, active low.
- bb_oe  out  1  bb_out enable, active high.
- a_out  out  32  address.
- a_oe  out  1  address/attribute enable, active high.
- d_in  in  32  data bus in.
- d_out  out  32  equals wr_data.
- d_oe  out  1  data transceiver enable, active low.
- ts  out  1  transfer start, active low.
- tip  out  1  transfer in progress, active low.
- rw  out  1  1=read.
- siz  out  2  equals the latched req_siz.
- tt  out  2  fixed 00 (normal access).
- tm  out  3  fixed 001 (user data).
- ta  in  1  transfer acknowledge, active low.
- tea  in  1  transfer error acknowledge, active low.

## Operation
- States: IDLE, ARB, ADDR, DATA, RELEASE.
- IDLE: on req_stb, latch addr/rw/siz, busy=1, next state ARB. beats_left=3 for a line transfer, otherwise 0. beat_idx=req_addr[3:2] for a line transfer, otherwise 0.
- ARB: br=0. Stay until the sampled bg=0 and bb_in=1, then go to ADDR.
- ADDR, 1 cycle: ts=0, tip=0, bb_oe=1, bb_out=0, a_oe=1, br=1. For writes, d_oe=0 from this cycle until RELEASE.
- DATA: ts=1, tip=0.
  - Each cycle, sample tea and ta.
  - tea=0 takes priority even if ta=0: err=1, go to RELEASE, no beat_ack.
  - ta=0: beat_ack=1, rd_data<=d_in (reads). If beats_left=0, go to RELEASE. Otherwise decrement beats_left and set beat_idx<=beat_idx+1, mod 4.
  - A per-beat counter clears on each beat. When it reaches TIMEOUT_CYCLES-1 with no termination: err=1, timeout=1, go to RELEASE.
- Line address: a_out holds the latched address for all beats. beat_idx wraps mod 4, so a start index of 2 gives beats 2,3,0,1. Byte/word/long transfers are single-beat, beat_idx=0.
- RELEASE, 1 cycle: tip=1, bb_out=1, bb_oe=1, a_oe=1, d_oe=1, done=1, busy=1. Next cycle: bb_oe=0, a_oe=0, busy=0, state IDLE.
- err and timeout hold their value until the next acceptance. A req_stb arriving while busy=1 is ignored.
- Reset values: br=1, ts=1, tip=1, bb_out=1, bb_oe=0, a_oe=0, d_oe=1, rw=1, siz=00, busy=0, beat_ack=0, done=0, err=0, timeout=0, beat_idx=0, rd_data=0, state IDLE.
- Reset mid-transfer: all outputs return to reset values at the next edge, and the bus is released immediately with no done pulse.

## Timing
- Acceptance: req_stb at edge N, then br=0 after edge N.
- Grant: grant sampled at edge G puts ts=0 in the cycle after G; ts is exactly one clock wide.
- Zero-wait beat: ta=0 sampled at the edge that ends the first DATA cycle. beat_ack is high in the following cycle.
- Minimum single transfer with immediate grant: req to done = 5 cycles (ARB, ADDR, DATA, RELEASE, done visible in RELEASE).
- Line burst with zero-wait TA: 4 consecutive beat_ack pulses.
- All outputs are registered except d_out.

## Test plan
- Long read 0x3000_0010, bg low, ta=0 on the 2nd DATA cycle, d_in=0xDEADBEEF -> one ts pulse; rd_data=0xDEADBEEF with beat_ack; done=1, err=0; tip high after.
- Line read at 0x0000_0008, zero-wait TA, d_in=beat number -> beat_idx sequence 2,3,0,1; 4 beat_ack pulses; a_out constant; a single ts.
- Byte write with bg held high for 10 cycles -> br low for those cycles, no ts; after grant, d_oe low through the beat; d_out=wr_data; done without err.
- tea=0 and ta=0 on the same edge on beat 2 of a line burst -> no beat_ack for that beat; err=1, timeout=0; RELEASE follows.
- No TA with TIMEOUT_CYCLES=8 -> done after 8 DATA cycles with err=1, timeout=1; bus released.
- rst low during DATA -> next edge: tip=1, bb_oe=0, a_oe=0, busy=0, no done; a new req then completes normally.
